// File: rtl/alu_core_pkg.sv
// Shared types, op codes and simple-op helpers for alu_core.
// The command struct width ALU_DATA_W must match the alu_core DATA_W parameter.
package alu_core_pkg;

    localparam int ALU_DATA_W = 8;

    localparam logic [2:0] OPC_NOP = 3'd0;
    localparam logic [2:0] OPC_ADD = 3'd1;
    localparam logic [2:0] OPC_AND = 3'd2;
    localparam logic [2:0] OPC_XOR = 3'd3;
    localparam logic [2:0] OPC_MUL = 3'd4;
    localparam logic [2:0] OPC_RST = 3'd7;

    typedef enum logic [2:0] {
        NO_OP  = OPC_NOP,
        ADD_OP = OPC_ADD,
        AND_OP = OPC_AND,
        XOR_OP = OPC_XOR,
        MUL_OP = OPC_MUL,
        RST_OP = OPC_RST
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    typedef struct packed {
        alu_op_t                 op;
        logic [ALU_DATA_W-1:0]   a;
        logic [ALU_DATA_W-1:0]   b;
    } alu_cmd_t;

    // Reserved codes 5 and 6 collapse to NO_OP so no illegal enum value is ever stored.
    function automatic alu_op_t decode_op(logic [2:0] code);
        alu_op_t op;
        case (code)
            OPC_ADD: op = ADD_OP;
            OPC_AND: op = AND_OP;
            OPC_XOR: op = XOR_OP;
            OPC_MUL: op = MUL_OP;
            OPC_RST: op = RST_OP;
            default: op = NO_OP;
        endcase
        return op;
    endfunction

    function automatic logic is_exec_op(alu_op_t op);
        return op inside {ADD_OP, AND_OP, XOR_OP, MUL_OP};
    endfunction

    function automatic logic [2*ALU_DATA_W-1:0] simple_result(alu_cmd_t cmd);
        logic [2*ALU_DATA_W-1:0] r;
        r = '0;
        case (cmd.op)
            ADD_OP:  r = {{(ALU_DATA_W-1){1'b0}}, {1'b0, cmd.a} + {1'b0, cmd.b}};
            AND_OP:  r = {{ALU_DATA_W{1'b0}}, cmd.a & cmd.b};
            XOR_OP:  r = {{ALU_DATA_W{1'b0}}, cmd.a ^ cmd.b};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_core_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, product ready MUL_LAT
// cycles after start. MUL_LAT below DATA_W truncates the product.
module alu_mul_seq #(
    parameter int DATA_W  = 8,
    parameter int MUL_LAT = DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [DATA_W-1:0]     a_i,
    input  logic [DATA_W-1:0]     b_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [2*DATA_W-1:0]   product_o
);

    localparam int CNT_W = $clog2(MUL_LAT);

    logic [2*DATA_W-1:0] acc_q;
    logic [2*DATA_W-1:0] acc_d;
    logic [2*DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0]   mplier_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                busy_q;

    assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
    // done_o flags the final step, so the product is presented combinationally that cycle.
    assign done_o    = busy_q && (cnt_q == CNT_W'(MUL_LAT - 1));
    assign product_o = acc_d;
    assign busy_o    = busy_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start_i) begin
            acc_q    <= '0;
            mcand_q  <= {{DATA_W{1'b0}}, a_i};
            mplier_q <= b_i;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (done_o) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_core.sv
// ALU command endpoint: valid/ready command intake, IDLE/EXEC/DONE FSM, done/result return.
// Optional one-entry command buffer enabled by defining ALU_CMD_BUFFER_EN.
module alu_core
    import alu_core_pkg::*;
#(
    parameter int DATA_W  = ALU_DATA_W,
    parameter int MUL_LAT = DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            alu_op,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    input  logic                  valid,
    output logic                  ready,
    output logic                  done,
    output logic [2*DATA_W-1:0]   result
);

    alu_state_t           state_q, state_d;
    alu_cmd_t             cmd_q, cmd_d;
    alu_cmd_t             in_cmd, launch_cmd;
    logic [2*DATA_W-1:0]  result_q, result_d;
    logic                 ready_q, ready_d;
    logic                 done_q;
    logic                 accept, launch;
    logic                 mul_start, mul_busy, mul_done;
    logic [2*DATA_W-1:0]  mul_product;

`ifdef ALU_CMD_BUFFER_EN
    alu_cmd_t             buf_q, buf_d;
    logic                 buf_valid_q, buf_valid_d;
`endif

    assign accept = valid && ready_q;
    assign ready  = ready_q;
    assign done   = done_q;
    assign result = result_q;

    always_comb begin
        in_cmd.op = decode_op(alu_op);
        in_cmd.a  = a;
        in_cmd.b  = b;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        result_d   = result_q;
        launch     = 1'b0;
        launch_cmd = in_cmd;
`ifdef ALU_CMD_BUFFER_EN
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
`endif
        unique case (state_q)
            IDLE: launch = accept;
            EXEC: begin
                if (cmd_q.op != MUL_OP || mul_done) begin
                    state_d  = DONE;
                    result_d = (cmd_q.op == MUL_OP) ? mul_product : simple_result(cmd_q);
                end
`ifdef ALU_CMD_BUFFER_EN
                if (accept && (is_exec_op(in_cmd.op) || in_cmd.op == RST_OP)) begin
                    buf_d       = in_cmd;
                    buf_valid_d = 1'b1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
`ifdef ALU_CMD_BUFFER_EN
                if (buf_valid_q) begin
                    launch      = 1'b1;
                    launch_cmd  = buf_q;
                    buf_valid_d = 1'b0;
                end else begin
                    launch = accept;
                end
`else
                launch = accept;
`endif
            end
            default: state_d = IDLE;
        endcase

        // no_op and reserved codes are consumed here with no effect.
        if (launch) begin
            if (is_exec_op(launch_cmd.op)) begin
                state_d = EXEC;
                cmd_d   = launch_cmd;
            end else if (launch_cmd.op == RST_OP) begin
                result_d = '0;
            end
        end

`ifdef ALU_CMD_BUFFER_EN
        ready_d = (state_d == IDLE) || !buf_valid_d;
`else
        ready_d = (state_d != EXEC);
`endif
    end

    assign mul_start = launch && (launch_cmd.op == MUL_OP) && !mul_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cmd_q    <= '{op: NO_OP, a: '0, b: '0};
            result_q <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            done_q   <= (state_d == DONE);
        end
    end

`ifdef ALU_CMD_BUFFER_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q       <= '{op: NO_OP, a: '0, b: '0};
            buf_valid_q <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
        end
    end
`endif

    alu_mul_seq #(
        .DATA_W  (DATA_W),
        .MUL_LAT (MUL_LAT)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (mul_start),
        .a_i       (launch_cmd.a),
        .b_i       (launch_cmd.b),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed scenarios plus randomized ops against
// an arithmetic reference model.
module tb_alu_core;

    localparam int DATA_W  = 8;
    localparam int MUL_LAT = 8;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd3;
    localparam logic [2:0] OP_MUL = 3'd4;
    localparam logic [2:0] OP_RST = 3'd7;

`ifdef ALU_CMD_BUFFER_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif

    logic                 clk;
    logic                 rst_n;
    logic [2:0]           alu_op;
    logic [DATA_W-1:0]    a;
    logic [DATA_W-1:0]    b;
    logic                 valid;
    logic                 ready;
    logic                 done;
    logic [2*DATA_W-1:0]  result;

    int total = 0;
    int bad   = 0;

    alu_core #(
        .DATA_W  (DATA_W),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .alu_op (alu_op),
        .a      (a),
        .b      (b),
        .valid  (valid),
        .ready  (ready),
        .done   (done),
        .result (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic int ref_alu(input int op, input int x, input int y);
        case (op)
            1:       return x + y;
            2:       return x & y;
            3:       return x ^ y;
            4:       return x * y;
            default: return 0;
        endcase
    endfunction

    // Presents a command and returns #1 after the edge that accepted it.
    task automatic issue(input logic [2:0] op, input logic [DATA_W-1:0] aa, input logic [DATA_W-1:0] bb);
        int waited;
        waited = 0;
        alu_op = op;
        a      = aa;
        b      = bb;
        valid  = 1'b1;
        while (ready !== 1'b1 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 50) check("issue_ready_timeout", ready, 1);
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    // Counts edges until done; also reports whether ready stayed low while waiting.
    task automatic wait_done(input string tag, input int max_cyc, output int lat, output bit ready_low);
        lat       = 0;
        ready_low = 1'b1;
        while (done !== 1'b1 && lat < max_cyc) begin
            if (ready !== 1'b0) ready_low = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (done !== 1'b1) check({tag, "_done_timeout"}, done, 1);
    endtask

    task automatic watch(input int cycles, output int pulses);
        pulses = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
        end
    endtask

    initial begin
        int          lat;
        bit          rlow;
        int          pulses;
        int          exp_result;
        logic [2:0]  op;
        logic [7:0]  ra, rb;

        rst_n  = 1'b0;
        valid  = 1'b0;
        alu_op = OP_NOP;
        a      = '0;
        b      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", ready, 1);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // add with carry into bit DATA_W
        issue(OP_ADD, 8'hFF, 8'h01);
        check("t1_ready_busy", ready, BUF_EN ? 1 : 0);
        wait_done("t1", 10, lat, rlow);
        check("t1_latency", lat, 1);
        check("t1_result", result, 16'h0100);
        check("t1_ready_back", ready, 1);
        @(posedge clk); #1;
        check("t1_done_pulse", done, 0);
        check("t1_result_hold", result, 16'h0100);

        // full-scale multiply
        issue(OP_MUL, 8'hFF, 8'hFF);
        wait_done("t2", 40, lat, rlow);
        check("t2_latency", lat, MUL_LAT);
        check("t2_result", result, 16'hFE01);
        check("t2_ready_low", rlow, BUF_EN ? 0 : 1);
        check("t2_ready_done", ready, 1);
        exp_result = 16'hFE01;

`ifndef ALU_CMD_BUFFER_EN
        // xor held valid during a multiply, with operands changing under the mul in flight
        ra = 8'($urandom_range(1, 255));
        rb = 8'($urandom_range(1, 255));
        issue(OP_MUL, ra, rb);
        alu_op = OP_XOR;
        a      = 8'hA5;
        b      = 8'h0F;
        valid  = 1'b1;
        wait_done("t3_mul", 40, lat, rlow);
        check("t3_mul_latency", lat, MUL_LAT);
        check("t3_mul_result", result, ref_alu(4, int'(ra), int'(rb)));
        check("t3_ready_low", rlow, 1);
        check("t3_ready_done", ready, 1);
        @(posedge clk); #1;
        valid = 1'b0;
        check("t3_accept_no_done", done, 0);
        wait_done("t3_xor", 10, lat, rlow);
        check("t3_xor_latency", lat, 1);
        check("t3_xor_result", result, 16'h00AA);
        exp_result = 16'h00AA;
`else
        // mul followed immediately by add; add waits in the buffer
        issue(OP_MUL, 8'h03, 8'h05);
        check("t6_ready_buf", ready, 1);
        issue(OP_ADD, 8'h01, 8'h02);
        wait_done("t6_mul", 40, lat, rlow);
        check("t6_mul_latency", lat, MUL_LAT - 1);
        check("t6_mul_result", result, 16'h000F);
        @(posedge clk); #1;
        check("t6_gap_no_done", done, 0);
        wait_done("t6_add", 10, lat, rlow);
        check("t6_add_gap", lat, 1);
        check("t6_add_result", result, 16'h0003);
        exp_result = 16'h0003;
`endif

        // asynchronous reset in the middle of a multiply
        issue(OP_MUL, 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)));
        repeat (3) @(posedge clk);
        #1;
        check("t4_result_before", result, exp_result);
        rst_n = 1'b0;
        #1;
        check("t4_ready_rst", ready, 1);
        check("t4_done_rst", done, 0);
        check("t4_result_rst", result, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        watch(12, pulses);
        check("t4_no_done_after", pulses, 0);
        check("t4_result_after", result, 0);

        // no_op, reserved codes and rst_op
        issue(OP_ADD, 8'hFF, 8'h01);
        wait_done("t5_add", 10, lat, rlow);
        check("t5_add_result", result, 16'h0100);
        issue(OP_NOP, 8'($urandom), 8'($urandom));
        issue(3'd5, 8'($urandom), 8'($urandom));
        issue(3'd6, 8'($urandom), 8'($urandom));
        watch(4, pulses);
        check("t5_nop_rsvd_no_done", pulses, 0);
        check("t5_nop_rsvd_result", result, 16'h0100);
        check("t5_nop_rsvd_ready", ready, 1);
        issue(OP_RST, 8'($urandom), 8'($urandom));
        check("t5_rst_result", result, 0);
        check("t5_rst_done", done, 0);
        watch(4, pulses);
        check("t5_rst_no_done", pulses, 0);

        // randomized back-to-back ops; inputs scrambled right after each accept
        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(1, 4));
            ra = 8'($urandom);
            rb = 8'($urandom);
            issue(op, ra, rb);
            alu_op = 3'($urandom_range(0, 7));
            a      = 8'($urandom);
            b      = 8'($urandom);
            wait_done("rnd", 40, lat, rlow);
            check($sformatf("rnd%0d_op%0d_latency", i, op), lat, (op == OP_MUL) ? MUL_LAT : 1);
            check($sformatf("rnd%0d_op%0d_result", i, op), result, ref_alu(int'(op), int'(ra), int'(rb)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
